siteswap_validator: RTL and testbench

- Upstream feeder for the trajectory generator. Collects siteswap throw digits one at a time from the UI/input decoder.
- Checks that the sequence is a juggleable siteswap: landing slots are collision-free, the digit sum divides evenly by the period, and the ball count is non-zero.
- Publishes the pattern array, ball count and a level-held pattern_valid that the trajectory generator samples in its INIT state.

---
 rtl/siteswap_pkg.sv | 30 +++
 rtl/siteswap_validator.sv | 212 +++++++++++++++++++++
 tb/tb_siteswap_validator.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/siteswap_pkg.sv
// Shared constants, enums and the small modulo helper for the siteswap validator.
package siteswap_pkg;

   localparam int DIGIT_W = 3;
   localparam int MAX_LEN = 7;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_COLLISION = 2'd1,
      ERR_OVERFLOW  = 2'd2,
      ERR_EMPTY     = 2'd3
   } err_code_e;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_CHECK   = 2'd1,
      ST_DIV     = 2'd2
   } state_e;

   // value is at most 13 and len at least 1, so 13 conditional subtractions always suffice
   function automatic logic [2:0] mod_small(input logic [3:0] value, input logic [2:0] len);
      logic [3:0] v;
      v = value;
      for (int i = 0; i < 13; i++) begin
         if ((len != 3'd0) && (v >= {1'b0, len})) v = v - {1'b0, len};
      end
      return v[2:0];
   endfunction

endpackage

// File: rtl/siteswap_validator.sv
// Collects siteswap digits, checks landing collisions and ball count, publishes the pattern.
// Build option REPEAT_FILL_EN: pattern_out entries past the period repeat the pattern instead of reading 0.
//
// state      | meaning
// ST_COLLECT | accepting digits, waiting for commit; outputs held
// ST_CHECK   | one digit per cycle: landing slot collision test and digit sum
// ST_DIV     | restoring divide of sum by period to get the ball count
module siteswap_validator
   import siteswap_pkg::*;
(
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [DIGIT_W-1:0] digit_in,
   input  logic               digit_valid_in,
   input  logic               commit_in,
   input  logic               clear_in,
   output logic [DIGIT_W-1:0] pattern_out [MAX_LEN-1:0],
   output logic [2:0]         num_balls_out,
   output logic [2:0]         pattern_len_out,
   output logic               pattern_valid,
   output logic               error_out,
   output logic [1:0]         err_code_out,
   output logic               busy_out
);

   state_e             state_q, state_d;
   logic [2:0]         len_q, len_d;
   logic               ovf_q, ovf_d;
   logic [DIGIT_W-1:0] buf_q [MAX_LEN-1:0];
   logic [DIGIT_W-1:0] buf_d [MAX_LEN-1:0];
   logic [2:0]         k_q, k_d;
   logic [MAX_LEN-1:0] bitmap_q, bitmap_d;
   logic [5:0]         sum_q, sum_d;
   logic [5:0]         rem_q, rem_d;
   logic [2:0]         quo_q, quo_d;
   logic [DIGIT_W-1:0] pat_q [MAX_LEN-1:0];
   logic [DIGIT_W-1:0] pat_d [MAX_LEN-1:0];
   logic [2:0]         balls_q, balls_d;
   logic [2:0]         plen_q, plen_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   err_code_e          code_q, code_d;

   logic [DIGIT_W-1:0] cur_digit;
   logic [2:0]         slot;
   logic [2:0]         len_a;
   logic               ovf_a;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      ovf_d    = ovf_q;
      buf_d    = buf_q;
      k_d      = k_q;
      bitmap_d = bitmap_q;
      sum_d    = sum_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      pat_d    = pat_q;
      balls_d  = balls_q;
      plen_d   = plen_q;
      valid_d  = valid_q;
      err_d    = err_q;
      code_d   = code_q;
      len_a    = len_q;
      ovf_a    = ovf_q;

      cur_digit = buf_q[k_q];
      slot      = mod_small({1'b0, k_q} + {1'b0, cur_digit}, len_q);

      if (clear_in) begin
         state_d = ST_COLLECT;
         len_d   = '0;
         ovf_d   = 1'b0;
         for (int i = 0; i < MAX_LEN; i++) pat_d[i] = '0;
         balls_d = '0;
         plen_d  = '0;
         valid_d = 1'b0;
         err_d   = 1'b0;
         code_d  = ERR_NONE;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               // a digit arriving with commit is appended before the commit is evaluated
               if (digit_valid_in) begin
                  if (len_q == 3'(MAX_LEN)) begin
                     ovf_a = 1'b1;
                  end else begin
                     buf_d[len_q] = digit_in;
                     len_a        = len_q + 3'd1;
                  end
               end
               len_d = len_a;
               ovf_d = ovf_a;
               if (commit_in) begin
                  if (ovf_a || (len_a == 3'd0)) begin
                     err_d   = 1'b1;
                     code_d  = ovf_a ? ERR_OVERFLOW : ERR_EMPTY;
                     valid_d = 1'b0;
                     len_d   = '0;
                     ovf_d   = 1'b0;
                  end else begin
                     state_d  = ST_CHECK;
                     k_d      = '0;
                     bitmap_d = '0;
                     sum_d    = '0;
                     valid_d  = 1'b0;
                  end
               end
            end
            ST_CHECK: begin
               if (k_q == len_q) begin
                  state_d = ST_DIV;
                  rem_d   = sum_q;
                  quo_d   = '0;
               end else if (bitmap_q[slot]) begin
                  state_d = ST_COLLECT;
                  err_d   = 1'b1;
                  code_d  = ERR_COLLISION;
                  len_d   = '0;
                  ovf_d   = 1'b0;
               end else begin
                  bitmap_d[slot] = 1'b1;
                  sum_d          = sum_q + {3'd0, cur_digit};
                  k_d            = k_q + 3'd1;
               end
            end
            ST_DIV: begin
               if (rem_q >= {3'd0, len_q}) begin
                  rem_d = rem_q - {3'd0, len_q};
                  quo_d = quo_q + 3'd1;
               end else begin
                  state_d = ST_COLLECT;
                  len_d   = '0;
                  ovf_d   = 1'b0;
                  // a remainder is impossible after a clean CHECK; treat it as a collision anyway
                  if (rem_q != 6'd0) begin
                     err_d  = 1'b1;
                     code_d = ERR_COLLISION;
                  end else if (quo_q == 3'd0) begin
                     err_d  = 1'b1;
                     code_d = ERR_EMPTY;
                  end else begin
                     for (int i = 0; i < MAX_LEN; i++) begin
`ifdef REPEAT_FILL_EN
                        pat_d[i] = buf_q[mod_small(4'(i), len_q)];
`else
                        pat_d[i] = (3'(i) < len_q) ? buf_q[i] : '0;
`endif
                     end
                     balls_d = quo_q;
                     plen_d  = len_q;
                     valid_d = 1'b1;
                     err_d   = 1'b0;
                     code_d  = ERR_NONE;
                  end
               end
            end
            default: state_d = ST_COLLECT;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= ST_COLLECT;
         len_q    <= '0;
         ovf_q    <= 1'b0;
         k_q      <= '0;
         bitmap_q <= '0;
         sum_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         balls_q  <= '0;
         plen_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= ERR_NONE;
         for (int i = 0; i < MAX_LEN; i++) begin
            buf_q[i] <= '0;
            pat_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         ovf_q    <= ovf_d;
         k_q      <= k_d;
         bitmap_q <= bitmap_d;
         sum_q    <= sum_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         balls_q  <= balls_d;
         plen_q   <= plen_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         code_q   <= code_d;
         for (int i = 0; i < MAX_LEN; i++) begin
            buf_q[i] <= buf_d[i];
            pat_q[i] <= pat_d[i];
         end
      end
   end

   assign pattern_out     = pat_q;
   assign num_balls_out   = balls_q;
   assign pattern_len_out = plen_q;
   assign pattern_valid   = valid_q;
   assign error_out       = err_q;
   assign err_code_out    = code_q;
   assign busy_out        = (state_q != ST_COLLECT);

endmodule

// File: tb/tb_siteswap_validator.sv
// Directed bench for siteswap_validator: latency, collision, overflow, empty, reset-abort and clear cases.
module tb_siteswap_validator;
   import siteswap_pkg::*;

   logic               clk_in = 1'b0;
   logic               rst_in = 1'b0;
   logic [DIGIT_W-1:0] digit_in = '0;
   logic               digit_valid_in = 1'b0;
   logic               commit_in = 1'b0;
   logic               clear_in = 1'b0;
   logic [DIGIT_W-1:0] pattern_out [MAX_LEN-1:0];
   logic [2:0]         num_balls_out;
   logic [2:0]         pattern_len_out;
   logic               pattern_valid;
   logic               error_out;
   logic [1:0]         err_code_out;
   logic               busy_out;

   int n_cmp = 0;
   int n_err = 0;

   siteswap_validator dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .digit_in        (digit_in),
      .digit_valid_in  (digit_valid_in),
      .commit_in       (commit_in),
      .clear_in        (clear_in),
      .pattern_out     (pattern_out),
      .num_balls_out   (num_balls_out),
      .pattern_len_out (pattern_len_out),
      .pattern_valid   (pattern_valid),
      .error_out       (error_out),
      .err_code_out    (err_code_out),
      .busy_out        (busy_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input logic [2:0] d);
      digit_in       = d;
      digit_valid_in = 1'b1;
      tick();
      digit_valid_in = 1'b0;
   endtask

   task automatic commit();
      commit_in = 1'b1;
      tick();
      commit_in = 1'b0;
   endtask

   // expected pattern array built from up to three source digits
   task automatic chk_pat(input string tag, input logic [2:0] s0, input logic [2:0] s1,
                          input logic [2:0] s2, input int len);
      logic [2:0] src [3];
      logic [2:0] exp;
      src[0] = s0;
      src[1] = s1;
      src[2] = s2;
      for (int i = 0; i < MAX_LEN; i++) begin
`ifdef REPEAT_FILL_EN
         exp = src[i % len];
`else
         exp = (i < len) ? src[i] : 3'd0;
`endif
         chk($sformatf("%s_pat%0d", tag, i), 32'(pattern_out[i]), 32'(exp));
      end
   endtask

   initial begin
      #12;
      chk("rst_valid", 32'(pattern_valid), 32'd0);
      chk("rst_err",   32'(error_out),     32'd0);
      chk("rst_code",  32'(err_code_out),  32'd0);
      chk("rst_busy",  32'(busy_out),      32'd0);
      chk("rst_balls", 32'(num_balls_out), 32'd0);
      chk("rst_len",   32'(pattern_len_out), 32'd0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      tick();

      // 5,3,1: three balls, valid at E8
      push(3'd5); push(3'd3); push(3'd1);
      commit();
      chk("p531_busy_e0", 32'(busy_out), 32'd1);
      ticks(7);
      chk("p531_busy_e7",  32'(busy_out),      32'd1);
      chk("p531_valid_e7", 32'(pattern_valid), 32'd0);
      tick();
      chk("p531_valid_e8", 32'(pattern_valid), 32'd1);
      chk("p531_busy_e8",  32'(busy_out),      32'd0);
      chk("p531_balls",    32'(num_balls_out), 32'd3);
      chk("p531_len",      32'(pattern_len_out), 32'd3);
      chk("p531_err",      32'(error_out),     32'd0);
      chk_pat("p531", 3'd5, 3'd3, 3'd1, 3);

      // 4,3,2: collision detected on the second CHECK cycle
      push(3'd4); push(3'd3); push(3'd2);
      commit();
      chk("p432_valid_drop", 32'(pattern_valid), 32'd0);
      tick();
      chk("p432_busy_e1", 32'(busy_out), 32'd1);
      tick();
      chk("p432_busy_e2", 32'(busy_out),     32'd0);
      chk("p432_err",     32'(error_out),    32'd1);
      chk("p432_code",    32'(err_code_out), 32'd1);
      chk("p432_valid",   32'(pattern_valid), 32'd0);

      // single 3: valid at E6
      push(3'd3);
      commit();
      ticks(5);
      chk("p3_valid_e5", 32'(pattern_valid), 32'd0);
      tick();
      chk("p3_valid_e6", 32'(pattern_valid), 32'd1);
      chk("p3_balls",    32'(num_balls_out), 32'd3);
      chk("p3_len",      32'(pattern_len_out), 32'd1);
      chk("p3_err",      32'(error_out),     32'd0);
      chk("p3_code",     32'(err_code_out),  32'd0);
      chk_pat("p3", 3'd3, 3'd0, 3'd0, 1);

      // single 0: zero balls
      push(3'd0);
      commit();
      ticks(3);
      chk("p0_err",   32'(error_out),     32'd1);
      chk("p0_code",  32'(err_code_out),  32'd3);
      chk("p0_valid", 32'(pattern_valid), 32'd0);
      chk("p0_busy",  32'(busy_out),      32'd0);

      // eight 7s: overflow, buffer cleared so the next commit is empty
      for (int i = 0; i < 8; i++) push(3'd7);
      commit();
      chk("ovf_err",  32'(error_out),    32'd1);
      chk("ovf_code", 32'(err_code_out), 32'd2);
      chk("ovf_busy", 32'(busy_out),     32'd0);
      commit();
      chk("empty_err",  32'(error_out),    32'd1);
      chk("empty_code", 32'(err_code_out), 32'd3);

      // 7,7,7 with reset in DIV
      push(3'd7); push(3'd7); push(3'd7);
      commit();
      ticks(6);
      chk("p777_busy_div", 32'(busy_out), 32'd1);
      #3;
      rst_in = 1'b0;
      #1;
      chk("arst_busy",  32'(busy_out),      32'd0);
      chk("arst_err",   32'(error_out),     32'd0);
      chk("arst_code",  32'(err_code_out),  32'd0);
      chk("arst_balls", 32'(num_balls_out), 32'd0);
      chk("arst_len",   32'(pattern_len_out), 32'd0);
      chk("arst_pat0",  32'(pattern_out[0]), 32'd0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      tick();

      // 4,4 after reset: valid at E8
      push(3'd4); push(3'd4);
      commit();
      ticks(7);
      chk("p44_valid_e7", 32'(pattern_valid), 32'd0);
      tick();
      chk("p44_valid_e8", 32'(pattern_valid), 32'd1);
      chk("p44_balls",    32'(num_balls_out), 32'd4);
      chk("p44_len",      32'(pattern_len_out), 32'd2);
      chk_pat("p44", 3'd4, 3'd4, 3'd0, 2);

      // empty commit right after a successful result
      commit();
      chk("empty2_err",   32'(error_out),     32'd1);
      chk("empty2_code",  32'(err_code_out),  32'd3);
      chk("empty2_valid", 32'(pattern_valid), 32'd0);

      // digit and commit in the same cycle
      digit_in       = 3'd3;
      digit_valid_in = 1'b1;
      commit_in      = 1'b1;
      tick();
      digit_valid_in = 1'b0;
      commit_in      = 1'b0;
      ticks(5);
      chk("sim3_valid_e5", 32'(pattern_valid), 32'd0);
      tick();
      chk("sim3_valid_e6", 32'(pattern_valid), 32'd1);
      chk("sim3_balls",    32'(num_balls_out), 32'd3);
      chk("sim3_len",      32'(pattern_len_out), 32'd1);

      // clear during CHECK aborts and zeroes outputs
      push(3'd5); push(3'd3); push(3'd1);
      commit();
      tick();
      chk("clr_busy_pre", 32'(busy_out), 32'd1);
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      chk("clr_busy",  32'(busy_out),      32'd0);
      chk("clr_valid", 32'(pattern_valid), 32'd0);
      chk("clr_balls", 32'(num_balls_out), 32'd0);
      chk("clr_len",   32'(pattern_len_out), 32'd0);
      chk("clr_err",   32'(error_out),     32'd0);
      ticks(10);
      chk("clr_stay_valid", 32'(pattern_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
